// File: rtl/prog_rom_arbiter.sv
// prog_rom_arbiter: shares one synchronous program ROM read port between the
// CPU fetch path and the debug/loader readback path.
//  - The CPU wins by default. A counter of consecutive denied debug cycles
//    forces one debug grant once it reaches MAX_WAIT.
//  - ROM_ADDR carries the granted address and holds the last granted address
//    when nothing is granted.
//  - The response is tagged to its requester and valid one cycle after the grant.
// Optional feature: define DBG_LOCK_EN to add the DBG_LOCK input. While DBG_LOCK
// is high the CPU is locked out and every debug request is granted.
module prog_rom_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 18,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    output logic              CPU_GNT,
    output logic              CPU_VALID,
    output logic [DATA_W-1:0] CPU_DATA,
    input  logic              DBG_REQ,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    output logic              DBG_GNT,
    output logic              DBG_VALID,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA
`ifdef DBG_LOCK_EN
    ,
    input  logic              DBG_LOCK
`endif
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_CPU_PRI   = 1'b0,
        ST_DBG_FORCE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_nxt;
    logic [ADDR_W-1:0]   r_addr_last;
    logic                r_cpu_pend;
    logic                r_dbg_pend;
    logic [DATA_W-1:0]   r_cpu_data;
    logic [DATA_W-1:0]   r_dbg_data;
    logic                w_cpu_gnt;
    logic                w_dbg_gnt;
    logic                w_lock;
    logic [ADDR_W-1:0]   w_rom_addr;

`ifdef DBG_LOCK_EN
    assign w_lock = DBG_LOCK;
`else
    assign w_lock = 1'b0;
`endif

    // Grant decision: lock and forced state favour debug, otherwise CPU first.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (RST) begin
            w_cpu_gnt = 1'b0;
            w_dbg_gnt = 1'b0;
        end else if (w_lock) begin
            w_dbg_gnt = DBG_REQ;
        end else if (r_state == ST_DBG_FORCE) begin
            w_dbg_gnt = DBG_REQ;
        end else begin
            w_cpu_gnt = CPU_REQ;
            w_dbg_gnt = DBG_REQ & ~CPU_REQ;
        end
    end

    // ROM address mux: the granted address, else the last granted one.
    always_comb begin
        w_rom_addr = r_addr_last;
        if (w_cpu_gnt) begin
            w_rom_addr = CPU_ADDR;
        end else if (w_dbg_gnt) begin
            w_rom_addr = DBG_ADDR;
        end else begin
            w_rom_addr = r_addr_last;
        end
    end

    // Starvation counter and FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        if (w_lock) begin
            w_state_nxt = ST_CPU_PRI;
            w_wait_nxt  = 4'd0;
        end else begin
            case (r_state)
                ST_CPU_PRI: begin
                    if (!DBG_REQ || w_dbg_gnt) begin
                        w_wait_nxt = 4'd0;
                    end else if (r_wait_cnt < LP_MAX_WAIT) begin
                        w_wait_nxt = r_wait_cnt + 4'd1;
                    end else begin
                        w_wait_nxt = r_wait_cnt;
                    end
                    if (w_wait_nxt == LP_MAX_WAIT) begin
                        w_state_nxt = ST_DBG_FORCE;
                    end else begin
                        w_state_nxt = ST_CPU_PRI;
                    end
                end
                ST_DBG_FORCE: begin
                    // One cycle here: either debug is granted or it gave up.
                    w_state_nxt = ST_CPU_PRI;
                    w_wait_nxt  = 4'd0;
                end
                default: begin
                    w_state_nxt = ST_CPU_PRI;
                    w_wait_nxt  = 4'd0;
                end
            endcase
        end
    end

    // State, address history, response tags and held response data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_CPU_PRI;
            r_wait_cnt  <= 4'd0;
            r_addr_last <= '0;
            r_cpu_pend  <= 1'b0;
            r_dbg_pend  <= 1'b0;
            r_cpu_data  <= '0;
            r_dbg_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_addr_last <= w_rom_addr;
            r_cpu_pend  <= w_cpu_gnt;
            r_dbg_pend  <= w_dbg_gnt;
            if (r_cpu_pend) begin
                r_cpu_data <= ROM_DATA;
            end else begin
                r_cpu_data <= r_cpu_data;
            end
            if (r_dbg_pend) begin
                r_dbg_data <= ROM_DATA;
            end else begin
                r_dbg_data <= r_dbg_data;
            end
        end
    end

    // The ROM output is already registered, so during the response cycle it is
    // passed straight through. The held copy covers the idle cycles.
    assign CPU_GNT   = w_cpu_gnt;
    assign DBG_GNT   = w_dbg_gnt;
    assign ROM_ADDR  = w_rom_addr;
    assign CPU_VALID = r_cpu_pend;
    assign DBG_VALID = r_dbg_pend;
    assign CPU_DATA  = r_cpu_pend ? ROM_DATA : r_cpu_data;
    assign DBG_DATA  = r_dbg_pend ? ROM_DATA : r_dbg_data;

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Testbench for prog_rom_arbiter.
//  - Expected responses go into a scoreboard queue when a grant is expected.
//  - A negedge monitor pops an entry and compares it on every VALID.
//  - ROM model: word[n] = 0x10000 + n.
// The DBG_LOCK_EN section runs only when that macro is defined.
module tb_prog_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CPU_REQ = 1'b0;
    logic [9:0]  CPU_ADDR = 10'd0;
    logic        CPU_GNT;
    logic        CPU_VALID;
    logic [17:0] CPU_DATA;
    logic        DBG_REQ = 1'b0;
    logic [9:0]  DBG_ADDR = 10'd0;
    logic        DBG_GNT;
    logic        DBG_VALID;
    logic [17:0] DBG_DATA;
    logic [9:0]  ROM_ADDR;
    logic [17:0] ROM_DATA = 18'd0;
`ifdef DBG_LOCK_EN
    logic        DBG_LOCK = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [18:0] sb[$];
    logic [17:0] last_cpu = 18'd0;
    logic [17:0] last_dbg = 18'd0;

    prog_rom_arbiter #(.ADDR_W(10), .DATA_W(18), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_GNT(CPU_GNT),
        .CPU_VALID(CPU_VALID), .CPU_DATA(CPU_DATA),
        .DBG_REQ(DBG_REQ), .DBG_ADDR(DBG_ADDR), .DBG_GNT(DBG_GNT),
        .DBG_VALID(DBG_VALID), .DBG_DATA(DBG_DATA),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
`ifdef DBG_LOCK_EN
        , .DBG_LOCK(DBG_LOCK)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [17:0] word(input logic [9:0] a);
        return 18'h10000 + {8'd0, a};
    endfunction

    // Synchronous ROM model with a registered output.
    always @(posedge CLK) ROM_DATA <= word(ROM_ADDR);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every response against the scoreboard and checks data hold.
    always @(negedge CLK) begin
        logic [18:0] e;
        if (RST) begin
            last_cpu = 18'd0;
            last_dbg = 18'd0;
        end else begin
            if (CPU_VALID && DBG_VALID) begin
                chk("both_valid", 32'd1, 32'd0);
            end else if (CPU_VALID || DBG_VALID) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {30'd0, CPU_VALID, DBG_VALID}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_tag", {31'd0, DBG_VALID}, {31'd0, e[18]});
                    chk("resp_data", {14'd0, (DBG_VALID ? DBG_DATA : CPU_DATA)}, {14'd0, e[17:0]});
                    if (DBG_VALID) last_dbg = e[17:0];
                    else last_cpu = e[17:0];
                end
            end else if (sb.size() != 0) begin
                chk("missing_valid", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (!CPU_VALID) chk("cpu_hold", {14'd0, CPU_DATA}, {14'd0, last_cpu});
            if (!DBG_VALID) chk("dbg_hold", {14'd0, DBG_DATA}, {14'd0, last_dbg});
        end
    end

    // One cycle of stimulus: drive at posedge+1, check grants after the negedge.
    task automatic step(input logic creq, input logic [9:0] caddr,
                        input logic dreq, input logic [9:0] daddr,
                        input logic ecg, input logic edg);
        CPU_REQ  = creq;
        CPU_ADDR = caddr;
        DBG_REQ  = dreq;
        DBG_ADDR = daddr;
        #5;
        chk("cpu_gnt", {31'd0, CPU_GNT}, {31'd0, ecg});
        chk("dbg_gnt", {31'd0, DBG_GNT}, {31'd0, edg});
        if (ecg) begin
            chk("rom_addr_cpu", {22'd0, ROM_ADDR}, {22'd0, caddr});
            sb.push_back({1'b0, word(caddr)});
        end
        if (edg) begin
            chk("rom_addr_dbg", {22'd0, ROM_ADDR}, {22'd0, daddr});
            sb.push_back({1'b1, word(daddr)});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cpu_gnt",   {31'd0, CPU_GNT},   32'd0);
        chk("rst_dbg_gnt",   {31'd0, DBG_GNT},   32'd0);
        chk("rst_cpu_valid", {31'd0, CPU_VALID}, 32'd0);
        chk("rst_dbg_valid", {31'd0, DBG_VALID}, 32'd0);
        chk("rst_cpu_data",  {14'd0, CPU_DATA},  32'd0);
        chk("rst_dbg_data",  {14'd0, DBG_DATA},  32'd0);
        chk("rst_rom_addr",  {22'd0, ROM_ADDR},  32'd0);
    endtask

    initial begin
        CPU_REQ = 1'b1;
        DBG_REQ = 1'b1;
        CPU_ADDR = 10'h155;
        DBG_ADDR = 10'h2AA;
        #12;
        chk_reset_outputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Back-to-back CPU fetches.
        step(1'b1, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b1, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b1, 10'h002, 1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Debug alone at the top address, then idle with the ROM address held.
        step(1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b1);
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("rom_addr_held", {22'd0, ROM_ADDR}, {22'd0, 10'h3FF});
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Continuous contention: pattern C C C C D, twice.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'h010 + 10'(i), 1'b1, 10'h200 + 10'(i / 5),
                 (i % 5) != 4, (i % 5) == 4);
        end
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Debug drops for one cycle, so the starvation count restarts.
        for (int i = 0; i < 3; i++) step(1'b1, 10'h040 + 10'(i), 1'b1, 10'h111, 1'b1, 1'b0);
        step(1'b1, 10'h043, 1'b0, 10'h111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 10'h050 + 10'(i), 1'b1, 10'h112, i != 4, i == 4);
        end
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Reset in the middle of a grant: the response is dropped.
        CPU_REQ  = 1'b1;
        CPU_ADDR = 10'h005;
        #5;
        chk("pre_rst_cpu_gnt", {31'd0, CPU_GNT}, 32'd1);
        RST = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge CLK);
        #1;
        chk_reset_outputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(1'b1, 10'h006, 1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);

`ifdef DBG_LOCK_EN
        // Lock: debug owns the ROM every cycle, the CPU never wins.
        DBG_LOCK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'h020 + 10'(i), 1'b1, 10'h300 + 10'(i), 1'b0, 1'b1);
        end
        DBG_LOCK = 1'b0;
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);
`endif

        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_rom_arbiter.md
Name: prog_rom_arbiter

Overview:
Shares the single synchronous 1024x18 program ROM read port between two requesters: the CPU instruction fetch path and the debug/loader readback path (UART memory dump).
- Sits between the ROM and both requesters.
- Drives the ROM address and routes the registered ROM data back, tagged with the requester that was granted.
- CPU has default priority. A starvation counter guarantees debug progress.

Parameters:
ADDR_W, 10, ROM address width
DATA_W, 18, ROM word width
MAX_WAIT, 4, consecutive denied debug-request cycles before debug is forced to win (range 1..15)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
CPU_REQ  in  1  CPU fetch request
CPU_ADDR  in  ADDR_W  CPU fetch address
CPU_GNT  out  1  CPU request accepted this cycle (combinational)
CPU_VALID  out  1  CPU_DATA valid (registered)
CPU_DATA  out  DATA_W  instruction word for CPU
DBG_REQ  in  1  debug read request
DBG_ADDR  in  ADDR_W  debug read address
DBG_GNT  out  1  debug request accepted this cycle (combinational)
DBG_VALID  out  1  DBG_DATA valid (registered)
DBG_DATA  out  DATA_W  word for debug
ROM_ADDR  out  ADDR_W  address to ROM; ROM samples it on the CLK rising edge
ROM_DATA  in  DATA_W  ROM registered output, valid one cycle after the address is sampled

Behaviour:
- Reset (async, immediate): FSM=CPU_PRI, wait_cnt=0, pending tag=none, CPU_VALID=DBG_VALID=0, CPU_DATA=DBG_DATA=0, ROM_ADDR=0. GNTs are 0 while RST is high.
- Handshake:
  - A requester holds REQ and ADDR stable until it sees GNT high in the same cycle.
  - Transfer occurs on the edge where REQ&GNT=1.
  - At most one GNT per cycle.
- ROM_ADDR is combinational: the granted requester's address; if no grant, the last granted address is held (register ROM_ADDR_last).
- Latency: response is exactly 1 cycle after grant. In the cycle after a grant, the matching VALID=1 for one cycle and its DATA=ROM_DATA, captured into the output register.
- DATA outputs hold their last value when VALID=0.
- Back-to-back grants are allowed every cycle (full throughput).
- FSM states:
  - CPU_PRI:
    - CPU_REQ wins.
    - DBG is granted only when CPU_REQ=0.
    - If DBG_REQ=1 and not granted, wait_cnt++ (saturating at MAX_WAIT).
    - If wait_cnt reaches MAX_WAIT, go to DBG_FORCE next cycle.
  - DBG_FORCE:
    - DBG granted unconditionally if DBG_REQ=1; CPU_GNT=0.
    - After that DBG grant, return to CPU_PRI.
    - If DBG_REQ drops before the grant, return to CPU_PRI.
    - wait_cnt cleared on either exit.
- wait_cnt is cleared on any DBG grant and in any cycle with DBG_REQ=0.
- Simultaneous requests in CPU_PRI with wait_cnt<MAX_WAIT: CPU granted, debug waits.
- Reset mid-operation: a pending response is dropped (no VALID after reset release); the first grant is possible in the first cycle after RST falls.
- Address wrap: none; addresses pass through unmodified (0x3FF is legal).

Optional Feature:
Macro DBG_LOCK_EN.
- Defined:
  - Adds input DBG_LOCK (1 bit).
  - While DBG_LOCK=1, CPU_GNT is forced 0 and DBG is granted whenever DBG_REQ=1.
  - wait_cnt is held at 0 and the FSM is held in CPU_PRI.
  - Used by the loader to freeze fetch during a dump.
- Not defined: port absent; behaviour identical to DBG_LOCK=0.

Test Plan:
- Reset, then CPU_REQ=1 with CPU_ADDR 0x000,0x001,0x002 on consecutive cycles (ROM preloaded word[n]=0x10000+n) -> CPU_GNT=1 each cycle; CPU_VALID=1 in cycles 2..4 with CPU_DATA 0x10000, 0x10001, 0x10002; DBG_VALID stays 0.
- DBG_REQ=1 only, DBG_ADDR=0x3FF -> DBG_GNT=1 same cycle; next cycle DBG_VALID=1, DBG_DATA=word[0x3FF]; CPU_VALID=0.
- CPU_REQ and DBG_REQ held high continuously, MAX_WAIT=4 -> CPU granted 4 cycles, DBG granted on the 5th (CPU_GNT=0), CPU resumes on the 6th; pattern repeats every 5 cycles.
- Assert RST one cycle after a CPU grant -> no CPU_VALID pulse; all outputs 0; after release a new CPU_REQ is granted in the first cycle.
- DBG_REQ high 3 cycles under CPU load, then low 1 cycle, then high again -> wait_cnt restarts from 0; no forced grant until 4 further denied cycles.
- With DBG_LOCK_EN defined, DBG_LOCK=1, CPU_REQ=DBG_REQ=1 for 10 cycles -> CPU_GNT=0 throughout, DBG_GNT=1 every cycle, 10 DBG_VALID pulses.
